// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand bypass, load-use stall, branch flush and data-memory wait/timeout control.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    input  logic        MemReqM,
    input  logic        dmem_ready,
    output logic        dmem_valid,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        EnableM,
    output logic        mem_err,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state;
    state_t     state_n;
    logic [7:0] wcnt;
    logic [7:0] wcnt_n;
    logic       memStall;
    logic       lwStall;

    // Memory-wait state and wait counter; reset abandons any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= 8'd0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // Next state, memory stall and handshake outputs.
    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        memStall   = 1'b0;
        dmem_valid = MemReqM;
        mem_err    = 1'b0;
        case (state)
            IDLE: begin
                memStall = MemReqM & ~dmem_ready;
                wcnt_n   = 8'd0;
                if (memStall) state_n = WAIT;
            end
            WAIT: begin
                memStall = ~dmem_ready;
                if (dmem_ready) begin
                    state_n = IDLE;
                    wcnt_n  = 8'd0;
                end else if (wcnt == TO) begin
                    state_n = ERR;
                end else begin
                    wcnt_n = wcnt + 8'd1;
                end
            end
            ERR: begin
                memStall   = 1'b1;
                dmem_valid = 1'b0;
                mem_err    = 1'b1;
            end
            default: begin
                state_n = IDLE;
                wcnt_n  = 8'd0;
            end
        endcase
    end

    // Operand bypass selects; the younger MEM result wins over WB.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
    end

    // Pipeline register controls: memory stall freezes everything, else branch flush and load-use.
    always_comb begin
        lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
        StallF  = lwStall;
        StallD  = lwStall;
        StallE  = 1'b0;
        EnableM = 1'b1;
        FlushW  = 1'b0;
        FlushD  = PCSrcE;
        FlushE  = PCSrcE | lwStall;
        if (memStall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            EnableM = 1'b0;
            FlushW  = 1'b1;
            FlushD  = 1'b0;
            FlushE  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Saturating stall-cycle and flush-cycle counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (StallF && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            if ((FlushD || FlushE) && flush_q != 32'hFFFF_FFFF)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flush_cnt    = flush_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: reference model compared every cycle plus directed literal checks.
// Built with TIMEOUT=4 so the memory timeout is reachable quickly.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
    logic [1:0]  ResultSrcE = '0;
    logic        PCSrcE = 1'b0;
    logic [4:0]  RdM = '0, RdW = '0;
    logic        RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic        MemReqM = 1'b0, dmem_ready = 1'b0;
    logic        dmem_valid;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushW, EnableM, mem_err;
    logic [31:0] perf_stall_cycles, perf_flush_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .dmem_ready(dmem_ready), .dmem_valid(dmem_valid),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .EnableM(EnableM),
        .mem_err(mem_err),
        .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is "pending" after a refused request until
    // ready arrives; the error latches after TIMEOUT+2 consecutive refused cycles.
    bit          m_pending, m_err;
    int          m_miss;
    longint      m_stall, m_flush;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit e_mem();
        if (m_err) return 1'b1;
        if (m_pending) return !dmem_ready;
        return MemReqM && !dmem_ready;
    endfunction

    function automatic bit e_lw();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic bit e_stallf();
        return e_mem() || e_lw();
    endfunction

    function automatic bit e_flushany();
        return !e_mem() && (PCSrcE || e_lw());
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pending = 0; m_err = 0; m_miss = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e_stallf() && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_flushany() && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (!m_err) begin
                if (e_mem()) begin
                    m_miss++;
                    m_pending = 1;
                    if (m_miss == TMO + 2) m_err = 1;
                end else begin
                    m_miss = 0;
                    m_pending = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            bit ms, lw;
            ms = e_mem();
            lw = e_lw();
            chk("m_fwdA", 32'(ForwardAE), 32'(fwd(Rs1E)));
            chk("m_fwdB", 32'(ForwardBE), 32'(fwd(Rs2E)));
            chk("m_stallF", 32'(StallF), 32'(ms | lw));
            chk("m_stallD", 32'(StallD), 32'(ms | lw));
            chk("m_stallE", 32'(StallE), 32'(ms));
            chk("m_enM", 32'(EnableM), 32'(!ms));
            chk("m_flushW", 32'(FlushW), 32'(ms));
            chk("m_flushD", 32'(FlushD), 32'(!ms & PCSrcE));
            chk("m_flushE", 32'(FlushE), 32'(!ms & (PCSrcE | lw)));
            chk("m_valid", 32'(dmem_valid), 32'(m_err ? 1'b0 : MemReqM));
            chk("m_err", 32'(mem_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
            chk("m_pstall", perf_stall_cycles, 32'(m_stall));
            chk("m_pflush", perf_flush_cnt, 32'(m_flush));
`else
            chk("m_pstall", perf_stall_cycles, 32'd0);
            chk("m_pflush", perf_flush_cnt, 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic clr_in();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0;
        PCSrcE = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; dmem_ready = 0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_valid", 32'(dmem_valid), 32'd0);
        chk("rst_pstall", perf_stall_cycles, 32'd0);
        chk("rst_pflush", perf_flush_cnt, 32'd0);
        MemReqM = 1'b1;
        #1 chk("rst_valid_follow", 32'(dmem_valid), 32'd1);
        MemReqM = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        tick();

        // Forwarding.
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        mid(); chk("fwdA_mem", 32'(ForwardAE), 32'd2);
        tick(); RdM = 0;
        mid(); chk("fwdA_wb", 32'(ForwardAE), 32'd1);
        tick(); RdM = 7; Rs2E = 7; RegWriteW = 0;
        mid(); chk("fwdB_mem", 32'(ForwardBE), 32'd2);
               chk("fwdA_none", 32'(ForwardAE), 32'd0);
        tick(); clr_in();

        // Load-use.
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        mid(); chk("lw_stallF", 32'(StallF), 32'd1);
               chk("lw_flushE", 32'(FlushE), 32'd1);
               chk("lw_flushD", 32'(FlushD), 32'd0);
        tick(); ResultSrcE = 2'b00;
        mid(); chk("lw_gone", 32'(StallF), 32'd0);
        tick(); ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        mid(); chk("lw_x0", 32'(StallF), 32'd0);

        // Branch together with load-use.
        tick(); RdE = 3; Rs1D = 3; PCSrcE = 1;
        mid(); chk("br_lw_fD", 32'(FlushD), 32'd1);
               chk("br_lw_fE", 32'(FlushE), 32'd1);
               chk("br_lw_sF", 32'(StallF), 32'd1);
        tick(); clr_in();
        pulse_reset();

        // Three refused memory cycles, then ready.
        MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                PCSrcE = 1; ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
            end
            mid();
            chk("mw_stallF", 32'(StallF), 32'd1);
            chk("mw_enM", 32'(EnableM), 32'd0);
            chk("mw_flushW", 32'(FlushW), 32'd1);
            chk("mw_valid", 32'(dmem_valid), 32'd1);
            if (i == 2) begin
                chk("mw_br_fD", 32'(FlushD), 32'd0);
                chk("mw_br_fE", 32'(FlushE), 32'd0);
            end
            tick();
            PCSrcE = 0; ResultSrcE = 0;
        end
        dmem_ready = 1;
        mid(); chk("mw_done_sF", 32'(StallF), 32'd0);
               chk("mw_done_enM", 32'(EnableM), 32'd1);
        tick(); MemReqM = 0; dmem_ready = 0;
        mid();
`ifdef HAZARD_PERF_CNT_EN
        chk("mw_pstall", perf_stall_cycles, 32'd3);
`else
        chk("mw_pstall", perf_stall_cycles, 32'd0);
`endif
        chk("mw_idle_sF", 32'(StallF), 32'd0);
        tick();
        pulse_reset();

        // Timeout into ERR.
        MemReqM = 1;
        for (int i = 0; i < TMO + 2; i++) tick();
        mid(); chk("to_err", 32'(mem_err), 32'd1);
               chk("to_valid", 32'(dmem_valid), 32'd0);
               chk("to_stallF", 32'(StallF), 32'd1);
        tick(); MemReqM = 0; dmem_ready = 1;
        mid(); chk("to_sticky", 32'(mem_err), 32'd1);
               chk("to_sticky_sF", 32'(StallF), 32'd1);
        #2 reset = 1;
        #1 chk("err_rst_err", 32'(mem_err), 32'd0);
           chk("err_rst_sF", 32'(StallF), 32'd0);
        #1 reset = 0;
        tick(); clr_in();

        // Asynchronous reset while waiting.
        MemReqM = 1;
        tick(); MemReqM = 0;
        mid(); chk("w_stall", 32'(StallF), 32'd1);
        #2 reset = 1;
        #1 chk("w_rst_sF", 32'(StallF), 32'd0);
           chk("w_rst_err", 32'(mem_err), 32'd0);
           chk("w_rst_valid", 32'(dmem_valid), 32'd0);
           chk("w_rst_pstall", perf_stall_cycles, 32'd0);
           chk("w_rst_pflush", perf_flush_cnt, 32'd0);
        #1 reset = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max memory-wait cycles before error (1..255).
REQ-002 SHALL have port clock  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports Rs1D, Rs2D  input  5 each  decode-stage source registers.
REQ-005 SHALL have ports Rs1E, Rs2E, RdE  input  5 each  execute-stage sources and destination.
REQ-006 SHALL have port ResultSrcE  input  2  execute-stage result select; 2'b01 = load.
REQ-007 SHALL have port PCSrcE  input  1  taken branch/jump resolved in EX.
REQ-008 SHALL have ports RdM (5), RegWriteM (1), RdW (5), RegWriteW (1)  input  MEM/WB destination and write flags.
REQ-009 SHALL have port MemReqM  input  1  load/store present in MEM.
REQ-010 SHALL have ports dmem_ready (input, 1) and dmem_valid (output, 1)  data-memory handshake.
REQ-011 SHALL have ports ForwardAE, ForwardBE  output  2 each  EX operand bypass selects.
REQ-012 SHALL have outputs StallF, StallD, StallE, FlushD, FlushE, FlushW, EnableM  1 each  pipeline-register controls (EnableM drives the EX/MEM register enable; FlushW drives the MEM/WB register flush).
REQ-013 SHALL have output mem_err  1  sticky memory-timeout flag.
REQ-014 SHALL have outputs perf_stall_cycles, perf_flush_cnt  32 each  performance counters.

Function
REQ-015 ForwardAE SHALL be 2'b10 if RegWriteM & RdM!=0 & RdM==Rs1E, else 2'b01 if RegWriteW & RdW!=0 & RdW==Rs1E, else 2'b00; ForwardBE likewise on Rs2E; MEM match wins.
REQ-016 lwStall SHALL be ResultSrcE==2'b01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-017 FSM states SHALL be IDLE, WAIT, ERR.
REQ-018 IDLE: memStall = MemReqM & !dmem_ready; next state WAIT when memStall, else IDLE.
REQ-019 WAIT: memStall = !dmem_ready; dmem_ready -> IDLE and wait counter cleared; otherwise counter increments; when the counter equals TIMEOUT and dmem_ready is low -> ERR.
REQ-020 ERR: memStall forced 1; dmem_valid 0; mem_err 1; exits only by reset.
REQ-021 dmem_valid SHALL equal MemReqM in IDLE and WAIT; handshake completes in the cycle where dmem_valid & dmem_ready.
REQ-022 With memStall=1: StallF=StallD=StallE=1, EnableM=0, FlushW=1, FlushD=FlushE=0; PCSrcE and lwStall ignored.
REQ-023 With memStall=0: StallF=StallD=lwStall, StallE=0, EnableM=1, FlushW=0, FlushD=PCSrcE, FlushE=PCSrcE|lwStall.
REQ-024 Precedence SHALL be memStall/ERR > branch flush > load-use; simultaneous PCSrcE and lwStall gives StallF=StallD=1, FlushD=FlushE=1.
REQ-025 All control outputs SHALL be combinational from inputs and the registered state; zero-cycle latency.

Reset
REQ-026 Reset SHALL force state IDLE, wait counter 0, mem_err 0, perf counters 0, asynchronously.
REQ-027 Reset asserted during WAIT/ERR SHALL abandon the access; dmem_valid SHALL then follow MemReqM (IDLE rule).

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: perf_stall_cycles SHALL increment each cycle StallF=1, and perf_flush_cnt SHALL increment each cycle FlushD|FlushE=1; both saturate at 32'hFFFFFFFF.
REQ-029 Macro HAZARD_PERF_CNT_EN undefined: both counter ports SHALL exist and read constant 0, with no counter flops.

Verification
REQ-030 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=2'b10; RdM=0 with RdW=5 -> ForwardAE=2'b01.
REQ-031 ResultSrcE=2'b01, RdE=3, Rs2D=3 -> StallF=StallD=1, FlushE=1, FlushD=0 for one cycle.
REQ-032 MemReqM=1, dmem_ready low 3 cycles then high -> 3 cycles of StallF=1, EnableM=0, FlushW=1; return to IDLE; perf_stall_cycles=3 (when enabled).
REQ-033 TIMEOUT=4, MemReqM=1, dmem_ready never high -> ERR entered, mem_err=1 and stalls stay asserted until reset.
REQ-034 PCSrcE=1 together with lwStall -> FlushD=FlushE=1, StallF=1; same stimulus during memStall -> FlushD=FlushE=0.
REQ-035 Reset pulse in WAIT -> state IDLE, mem_err=0, counters 0 immediately, without waiting for a clock edge.
